// File: rtl/chacha_block_stream.sv
// ChaCha block function with streaming keystream output.
//
// The host loads the 16-word input state as NB = 512/IO_W beats. Beats come
// word 0 first, and each word is little-endian. After the last beat the core
// runs 4*ROUNDS quarter-rounds, one per cycle, and then one feed-forward add.
// It then presents the keystream block, one beat at a time.
//
// Ports:
//   clk, rst     rising-edge clock and synchronous active-high reset
//   data_in, wr  load beat and load strobe (one beat per cycle)
//   data_out, rd current keystream beat and pop strobe
//   ready        a keystream block is available (OUT state)
//   busy         computing (CALC, SUM or INC)
//   auto_inc     sampled on the last pop: bump the counter and recompute
//   ctr_wrap     sticky flag: the counter wrapped to zero under auto-increment
//   dbg_state_o  current FSM state, for observation only
//
// Handshake: wr has no back-pressure. Every cycle with wr=1 consumes data_in.
// A wr outside IDLE/LOAD aborts the block and restarts loading at beat 0.
// data_out is valid whenever ready=1, and a cycle with ready=1 and rd=1 pops
// that beat. rd is ignored while ready=0. When wr and rd are both high, wr wins.
module chacha_block_stream #(
    parameter int ROUNDS = 20,
    parameter int IO_W   = 8,
    parameter int CTR_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IO_W-1:0] data_in,
    input  logic            wr,
    output logic [IO_W-1:0] data_out,
    input  logic            rd,
    output logic            ready,
    output logic            busy,
    input  logic            auto_inc,
    output logic            ctr_wrap,
    output logic [2:0]      dbg_state_o
);
    localparam int NB    = 512 / IO_W;
    localparam int PTR_W = $clog2(NB);
    localparam int NQR   = 4 * ROUNDS;
    localparam int QR_W  = $clog2(NQR);
    localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(NB - 1);
    localparam logic [QR_W-1:0]  LAST_QR   = QR_W'(NQR - 1);

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_block_stream: ROUNDS must be 8, 12 or 20");
    end
    if (!(IO_W == 8 || IO_W == 32)) begin : g_bad_io_w
        $error("chacha_block_stream: IO_W must be 8 or 32");
    end
    if (!(CTR_W == 32 || CTR_W == 64)) begin : g_bad_ctr_w
        $error("chacha_block_stream: CTR_W must be 32 or 64");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_SUM  = 3'd3,
        S_OUT  = 3'd4,
        S_INC  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QR_W-1:0]    qr_cnt_q, qr_cnt_d;
    logic               ctr_wrap_q, ctr_wrap_d;
    logic [511:0]       in_q, in_d;     // input state, word i at [32*i +: 32]
    logic [31:0]        work_q [16];
    logic [31:0]        work_d [16];

    logic               load_beat, abort;
    logic [8:0]         wr_bit, rd_bit;
    logic [511:0]       work_flat;
    logic [511:0]       in_inc;
    logic               inc_wrap;
    logic [31:0]        ctr32;
    logic [63:0]        ctr64;
    logic [1:0]         lane;
    logic [3:0]         ia, ib, ic, id;
    logic [31:0]        qa, qb, qc, qd;

    assign load_beat = wr && (state_q == S_IDLE || state_q == S_LOAD);
    assign abort     = wr && !load_beat;
    assign wr_bit    = 9'(wr_ptr_q) << $clog2(IO_W);
    assign rd_bit    = 9'(rd_ptr_q) << $clog2(IO_W);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (wr) state_d = (wr_ptr_q == LAST_BEAT) ? S_CALC : S_LOAD;
            end
            S_CALC: begin
                if (wr)                         state_d = S_LOAD;
                else if (qr_cnt_q == LAST_QR)   state_d = S_SUM;
            end
            S_SUM:  state_d = wr ? S_LOAD : S_OUT;
            S_OUT: begin
                if (wr)                                state_d = S_LOAD;
                else if (rd && rd_ptr_q == LAST_BEAT)  state_d = auto_inc ? S_INC : S_IDLE;
            end
            S_INC:  state_d = wr ? S_LOAD : S_CALC;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs. data_out is forced to zero outside OUT so that a reset or an
    // abort never exposes a partially computed block.
    always_comb begin
        for (int i = 0; i < 16; i++) work_flat[32*i +: 32] = work_q[i];
        ready       = (state_q == S_OUT);
        busy        = (state_q == S_CALC) || (state_q == S_SUM) || (state_q == S_INC);
        dbg_state_o = state_q;
        data_out    = ready ? work_flat[rd_bit +: IO_W] : '0;
        ctr_wrap    = ctr_wrap_q;
    end

    // Quarter-round lane selection. qr_cnt[2]=0 selects a column and 1 selects
    // a diagonal. On a diagonal, rows b/c/d are rotated by 1/2/3 lanes.
    always_comb begin
        lane = qr_cnt_q[1:0];
        ia   = {2'b00, lane};
        if (!qr_cnt_q[2]) begin
            ib = {2'b01, lane};
            ic = {2'b10, lane};
            id = {2'b11, lane};
        end else begin
            ib = {2'b01, 2'(lane + 2'd1)};
            ic = {2'b10, 2'(lane + 2'd2)};
            id = {2'b11, 2'(lane + 2'd3)};
        end
        qa = work_q[ia];
        qb = work_q[ib];
        qc = work_q[ic];
        qd = work_q[id];
        qa = qa + qb; qd = qd ^ qa; qd = {qd[15:0], qd[31:16]};
        qc = qc + qd; qb = qb ^ qc; qb = {qb[19:0], qb[31:20]};
        qa = qa + qb; qd = qd ^ qa; qd = {qd[23:0], qd[31:24]};
        qc = qc + qd; qb = qb ^ qc; qb = {qb[24:0], qb[31:25]};
    end

    // Counter increment: word 12, or words 13:12 when CTR_W is 64
    always_comb begin
        in_inc   = in_q;
        ctr32    = '0;
        ctr64    = '0;
        inc_wrap = 1'b0;
        if (CTR_W == 64) begin
            ctr64             = in_q[447:384] + 64'd1;
            in_inc[447:384]   = ctr64;
            inc_wrap          = (ctr64 == 64'd0);
        end else begin
            ctr32             = in_q[415:384] + 32'd1;
            in_inc[415:384]   = ctr32;
            inc_wrap          = (ctr32 == 32'd0);
        end
    end

    // Datapath next-state
    always_comb begin
        in_d       = in_q;
        work_d     = work_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        qr_cnt_d   = qr_cnt_q;
        ctr_wrap_d = ctr_wrap_q;
        if (load_beat) begin
            in_d[wr_bit +: IO_W] = data_in;
            if (wr_ptr_q == LAST_BEAT) begin
                // The working copy includes the beat stored on this edge
                for (int i = 0; i < 16; i++) work_d[i] = in_d[32*i +: 32];
                wr_ptr_d = '0;
                qr_cnt_d = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end else if (abort) begin
            in_d[IO_W-1:0] = data_in;
            wr_ptr_d       = PTR_W'(1);
            rd_ptr_d       = '0;
            ctr_wrap_d     = 1'b0;
        end else begin
            case (state_q)
                S_CALC: begin
                    work_d[ia] = qa;
                    work_d[ib] = qb;
                    work_d[ic] = qc;
                    work_d[id] = qd;
                    qr_cnt_d   = qr_cnt_q + 1'b1;
                end
                S_SUM: begin
                    for (int i = 0; i < 16; i++) work_d[i] = work_q[i] + in_q[32*i +: 32];
                    rd_ptr_d = '0;
                end
                S_OUT: begin
                    // Pointer wraps to 0 naturally after the last beat
                    if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
                end
                S_INC: begin
                    in_d = in_inc;
                    for (int i = 0; i < 16; i++) work_d[i] = in_inc[32*i +: 32];
                    qr_cnt_d   = '0;
                    ctr_wrap_d = ctr_wrap_q | inc_wrap;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            qr_cnt_q   <= '0;
            ctr_wrap_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            qr_cnt_q   <= qr_cnt_d;
            ctr_wrap_q <= ctr_wrap_d;
        end
    end

    // The state arrays are not cleared on reset. They are always rewritten
    // before use.
    always_ff @(posedge clk) begin
        in_q   <= in_d;
        work_q <= work_d;
    end

endmodule

// File: tb/tb_chacha_block_stream.sv
module tb_chacha_block_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  din8;
    logic [31:0] din32;
    wire  [7:0]  dout8;
    wire  [31:0] dout32;
    logic [1:0]  wr_s, rd_s, ai_s;
    wire  [1:0]  ready_s, busy_s, wrap_s;
    wire  [2:0]  dbg8, dbg32;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // unit 0: 8-bit beats, 32-bit counter
    chacha_block_stream #(.ROUNDS(20), .IO_W(8), .CTR_W(32)) u_dut8 (
        .clk(clk), .rst(rst), .data_in(din8), .wr(wr_s[0]), .data_out(dout8),
        .rd(rd_s[0]), .ready(ready_s[0]), .busy(busy_s[0]), .auto_inc(ai_s[0]),
        .ctr_wrap(wrap_s[0]), .dbg_state_o(dbg8)
    );

    // unit 1: 32-bit beats, 64-bit counter
    chacha_block_stream #(.ROUNDS(20), .IO_W(32), .CTR_W(64)) u_dut32 (
        .clk(clk), .rst(rst), .data_in(din32), .wr(wr_s[1]), .data_out(dout32),
        .rd(rd_s[1]), .ready(ready_s[1]), .busy(busy_s[1]), .auto_inc(ai_s[1]),
        .ctr_wrap(wrap_s[1]), .dbg_state_o(dbg32)
    );

    // ---------------- reference model ----------------
    function automatic logic [127:0] qr(input logic [127:0] v);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = v;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_ref(input logic [511:0] st, input int rounds);
        logic [31:0] x [16];
        logic [511:0] r;
        int ia, ib, ic, id;
        for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
        for (int dr = 0; dr < rounds / 2; dr++) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < 4; i++) begin
                    ia = i;
                    ib = 4 + ((i + p) % 4);
                    ic = 8 + ((i + 2 * p) % 4);
                    id = 12 + ((i + 3 * p) % 4);
                    {x[ia], x[ib], x[ic], x[id]} = qr({x[ia], x[ib], x[ic], x[id]});
                end
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + st[32*i +: 32];
        return r;
    endfunction

    function automatic logic [511:0] mk_state(input logic [255:0] key, input logic [31:0] w12,
                                              input logic [31:0] w13, input logic [31:0] w14,
                                              input logic [31:0] w15);
        logic [511:0] st;
        st[127:0]   = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        st[383:128] = key;
        st[415:384] = w12;
        st[447:416] = w13;
        st[479:448] = w14;
        st[511:480] = w15;
        return st;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // ---------------- check and driver tasks ----------------
    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load beats [start, stop) of st, with optional random idle gaps
    task automatic load(input int u, input logic [511:0] st, input int start, input int stop,
                        input int max_gap);
        int g;
        for (int k = start; k < stop; k++) begin
            if (max_gap > 0) begin
                g = $urandom_range(0, max_gap);
                repeat (g) begin @(posedge clk); #1; end
            end
            if (u == 0) din8 = st[8*k +: 8];
            else        din32 = st[32*k +: 32];
            wr_s[u] = 1'b1;
            @(posedge clk); #1;
            wr_s[u] = 1'b0;
        end
    endtask

    task automatic wait_ready(input int u, output int edges);
        edges = 0;
        while (ready_s[u] !== 1'b1 && edges < 300) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic pop(input int u, input int n, input bit ainc, output logic [511:0] got);
        int nb;
        nb  = (u == 0) ? 64 : 16;
        got = '0;
        for (int k = 0; k < n; k++) begin
            if (u == 0) got[8*k +: 8] = dout8;
            else        got[32*k +: 32] = dout32;
            rd_s[u] = 1'b1;
            ai_s[u] = (k == nb - 1) ? ainc : 1'b0;
            @(posedge clk); #1;
        end
        rd_s[u] = 1'b0;
        ai_s[u] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [511:0] st, st2, got, got2;
        logic [255:0] key, rfc_key;
        logic [31:0]  w13;
        int edges, cnt, nb;

        rst = 1'b1; wr_s = '0; rd_s = '0; ai_s = '0; din8 = '0; din32 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {ready_s, busy_s, wrap_s}, 6'b0);
        check("rst_dout8", dout8, 8'h00);
        check("rst_dout32", dout32, 32'h0);
        rst = 1'b0;

        for (int b = 0; b < 32; b++) rfc_key[8*b +: 8] = 8'(b);

        // RFC 8439 2.3.2 vector, byte beats
        st = mk_state(rfc_key, 32'h1, 32'h09000000, 32'h4a000000, 32'h0);
        load(0, st, 0, 64, 0);
        check("rfc8_busy", busy_s[0], 1'b1);
        wait_ready(0, edges);
        check("rfc8_latency", edges, 81);
        pop(0, 64, 1'b0, got);
        check("rfc8_first16", got[127:0], 128'hc47120a3_1fdd0f50_15593bd1_e4e7f110);
        check("rfc8_block", got, chacha_ref(st, 20));
        check("rfc8_idle", {ready_s[0], busy_s[0]}, 2'b00);

        // Same vector, word beats
        load(1, st, 0, 16, 0);
        wait_ready(1, edges);
        check("rfc32_latency", edges, 81);
        check("rfc32_word0", dout32, 32'he4e7f110);
        pop(1, 16, 1'b0, got);
        check("rfc32_block", got, chacha_ref(st, 20));

        // Auto-increment with zero key/nonce, counter 0
        st = mk_state('0, 32'h0, 32'h0, 32'h0, 32'h0);
        load(0, st, 0, 64, 0);
        wait_ready(0, edges);
        pop(0, 64, 1'b1, got);
        check("ainc_first8", got[63:0], 64'h903df1a0_ade0b876);
        check("ainc_block0", got, chacha_ref(st, 20));
        cnt = 0;
        while (busy_s[0] === 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("ainc_busy_cycles", cnt, 82);
        check("ainc_ready", ready_s[0], 1'b1);
        pop(0, 64, 1'b0, got2);
        check("ainc_next8", got2[63:0], 64'h7a385155_bee7079f);
        check("ainc_block1", got2, chacha_ref(mk_state('0, 32'h1, 32'h0, 32'h0, 32'h0), 20));
        check("ainc_nowrap", wrap_s[0], 1'b0);

        // 32-bit counter wrap: word 13 must stay put
        key = rand_key();
        w13 = $urandom;
        st  = mk_state(key, 32'hffffffff, w13, $urandom, $urandom);
        load(0, st, 0, 64, 0);
        wait_ready(0, edges);
        check("wrap32_pre", wrap_s[0], 1'b0);
        pop(0, 64, 1'b1, got);
        check("wrap32_block0", got, chacha_ref(st, 20));
        wait_ready(0, edges);
        check("wrap32_flag", wrap_s[0], 1'b1);
        st[415:384] = 32'h0;
        pop(0, 64, 1'b0, got);
        check("wrap32_block1", got, chacha_ref(st, 20));
        check("wrap32_sticky", wrap_s[0], 1'b1);

        // wr and rd together in OUT: wr wins, flag clears, pointer restarts
        st  = mk_state(rand_key(), $urandom, $urandom, $urandom, $urandom);
        st2 = mk_state(rand_key(), $urandom, $urandom, $urandom, $urandom);
        load(0, st, 0, 64, 0);
        wait_ready(0, edges);
        pop(0, $urandom_range(1, 10), 1'b0, got);
        din8 = st2[7:0];
        wr_s[0] = 1'b1;
        rd_s[0] = 1'b1;
        @(posedge clk); #1;
        wr_s[0] = 1'b0;
        rd_s[0] = 1'b0;
        check("abort_out_flags", {ready_s[0], busy_s[0], wrap_s[0]}, 3'b000);
        load(0, st2, 1, 64, 0);
        wait_ready(0, edges);
        check("abort_out_latency", edges, 81);
        pop(0, 64, 1'b0, got);
        check("abort_out_block", got, chacha_ref(st2, 20));

        // wr during CALC on the word-beat unit
        st  = mk_state(rand_key(), $urandom, $urandom, $urandom, $urandom);
        st2 = mk_state(rand_key(), $urandom, $urandom, $urandom, $urandom);
        load(1, st, 0, 16, 0);
        cnt = $urandom_range(3, 60);
        repeat (cnt) begin @(posedge clk); #1; end
        check("abort_calc_busy_before", busy_s[1], 1'b1);
        din32   = st2[31:0];
        wr_s[1] = 1'b1;
        @(posedge clk); #1;
        wr_s[1] = 1'b0;
        check("abort_calc_flags", {ready_s[1], busy_s[1]}, 2'b00);
        load(1, st2, 1, 16, 0);
        wait_ready(1, edges);
        check("abort_calc_latency", edges, 81);
        pop(1, 16, 1'b0, got);
        check("abort_calc_block", got, chacha_ref(st2, 20));

        // Reset mid-load, then a full reload
        st = mk_state(rand_key(), $urandom, $urandom, $urandom, $urandom);
        load(0, st, 0, 20, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_flags", {ready_s[0], busy_s[0], wrap_s[0], dout8}, 11'h0);
        st = mk_state(rand_key(), $urandom, $urandom, $urandom, $urandom);
        load(0, st, 0, 64, 0);
        wait_ready(0, edges);
        check("rst_mid_latency", edges, 81);
        pop(0, 64, 1'b0, got);
        check("rst_mid_block", got, chacha_ref(st, 20));

        // 64-bit counter carry into word 13, no wrap flag
        key = rand_key();
        st  = mk_state(key, 32'hffffffff, 32'h0, $urandom, $urandom);
        load(1, st, 0, 16, 2);
        wait_ready(1, edges);
        pop(1, 16, 1'b1, got);
        check("ctr64_block0", got, chacha_ref(st, 20));
        wait_ready(1, edges);
        check("ctr64_latency", edges, 82);
        check("ctr64_nowrap", wrap_s[1], 1'b0);
        st[447:384] = 64'h00000001_00000000;
        pop(1, 16, 1'b0, got);
        check("ctr64_block1", got, chacha_ref(st, 20));

        // Random states with random wr gaps on both units
        for (int t = 0; t < 3; t++) begin
            for (int u = 0; u < 2; u++) begin
                nb = (u == 0) ? 64 : 16;
                st = mk_state(rand_key(), $urandom, $urandom, $urandom, $urandom);
                load(u, st, 0, nb, 3);
                wait_ready(u, edges);
                check($sformatf("gap_latency_u%0d_t%0d", u, t), edges, 81);
                pop(u, nb, 1'b0, got);
                check($sformatf("gap_block_u%0d_t%0d", u, t), got, chacha_ref(st, 20));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
